// File: rtl/gate_pkg.sv
// Shared definitions for the 2-input gate sweep controller: gate encodings,
// expected truth tables and the sequencer state type.
package gate_pkg;

    // gate_sel encodings; 6 and 7 are reserved
    localparam logic [2:0] GATE_AND  = 3'd0;
    localparam logic [2:0] GATE_OR   = 3'd1;
    localparam logic [2:0] GATE_NAND = 3'd2;
    localparam logic [2:0] GATE_NOR  = 3'd3;
    localparam logic [2:0] GATE_XOR  = 3'd4;
    localparam logic [2:0] GATE_XNOR = 3'd5;

    // Expected truth tables, bit k = Y for {A,B} = k
    localparam logic [3:0] EXP_AND  = 4'b1000;
    localparam logic [3:0] EXP_OR   = 4'b1110;
    localparam logic [3:0] EXP_NAND = 4'b0111;
    localparam logic [3:0] EXP_NOR  = 4'b0001;
    localparam logic [3:0] EXP_XOR  = 4'b0110;
    localparam logic [3:0] EXP_XNOR = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // True for the six defined gate encodings
    function automatic logic gate_sel_valid(input logic [2:0] sel);
        return (sel <= GATE_XNOR);
    endfunction

    // Expected table for a gate encoding; reserved encodings map to 0 and are
    // flagged separately through gate_sel_valid
    function automatic logic [3:0] expected_table(input logic [2:0] sel);
        case (sel)
            GATE_AND:  return EXP_AND;
            GATE_OR:   return EXP_OR;
            GATE_NAND: return EXP_NAND;
            GATE_NOR:  return EXP_NOR;
            GATE_XOR:  return EXP_XOR;
            GATE_XNOR: return EXP_XNOR;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all four {A,B} combinations onto a 2-input gate, samples Y after a
// settle time per vector, and checks the captured truth table against the
// expected table for the gate type latched at start.
module gate_sweep_ctrl
    import gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] truth_table,
    output logic [3:0] err_mask
);

    // Last settle count of a vector window; each vector is held SETTLE_CYCLES+1 cycles
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_e     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] tt_q, tt_d;
    logic [3:0] err_q, err_d;

    // Next-state and registered-output logic for the IDLE/APPLY/CHECK sequencer
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        tt_d    = tt_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d   = gate_sel;
                    tt_d    = 4'b0000;
                    err_d   = 4'b0000;
                    pass_d  = 1'b0;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_APPLY;
                end
            end

            ST_APPLY: begin
                if (cnt_q == SETTLE_LAST) begin
                    // Last cycle of this vector's window: capture Y
                    tt_d[idx_q] = Y;
                    cnt_d       = 4'd0;
                    if (idx_q == 2'd3) begin
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = 2'd0;
                        // Compare uses tt_d so the vector-3 sample is included
                        err_d   = gate_sel_valid(sel_q) ? (tt_d ^ expected_table(sel_q)) : 4'hF;
                        pass_d  = (err_d == 4'b0000);
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        a_d   = idx_d[1];
                        b_d   = idx_d[0];
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_CHECK: begin
                // done is high for this one cycle; start here is dropped
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset that overrides everything
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 3'd0;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tt_q    <= 4'b0000;
            err_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
        end
    end

    assign A           = a_q;
    assign B           = b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign truth_table = tt_q;
    assign err_mask    = err_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: one instance with SETTLE_CYCLES=2 and
// one with SETTLE_CYCLES=1, each driving a behavioural gate model.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [2:0] sel0, sel1;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] tt0, err0, tt1, err1;

    // Gate model mode: 0 = AND, 1 = OR, 2 = tied 0
    int mode;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic gate_model(input int m, input logic a, input logic b);
        case (m)
            0:       return a & b;
            1:       return a | b;
            default: return 1'b0;
        endcase
    endfunction

    assign y0 = gate_model(mode, a0, b0);
    assign y1 = gate_model(mode, a1, b1);

    gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .gate_sel(sel0),
        .A(a0), .B(b0), .Y(y0), .busy(busy0), .done(done0), .pass(pass0),
        .truth_table(tt0), .err_mask(err0)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .gate_sel(sel1),
        .A(a1), .B(b1), .Y(y1), .busy(busy1), .done(done1), .pass(pass1),
        .truth_table(tt1), .err_mask(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full sweep on instance d (settle s); gate_sel is scrambled after
    // acceptance to show the latched value is used.
    task automatic do_sweep(input int d, input int s, input logic [2:0] sel, input int m,
                            input logic [3:0] tt_e, input logic pass_e, input logic [3:0] err_e);
        int win;
        logic a_s, b_s, busy_s, done_s, pass_s;
        logic [3:0] tt_s, err_s, k;
        win = 4 * (s + 1);
        mode = m;
        @(negedge clk);
        if (d == 0) begin start0 = 1'b1; sel0 = sel; end
        else        begin start1 = 1'b1; sel1 = sel; end
        for (int n = 1; n <= win + 2; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if (d == 0) begin start0 = 1'b0; sel0 = ~sel; end
                else        begin start1 = 1'b0; sel1 = ~sel; end
            end
            a_s    = (d == 0) ? a0 : a1;
            b_s    = (d == 0) ? b0 : b1;
            busy_s = (d == 0) ? busy0 : busy1;
            done_s = (d == 0) ? done0 : done1;
            pass_s = (d == 0) ? pass0 : pass1;
            tt_s   = (d == 0) ? tt0 : tt1;
            err_s  = (d == 0) ? err0 : err1;
            if (n <= win) begin
                k = 4'((n - 1) / (s + 1));
                check($sformatf("d%0d_vec_ab_n%0d", d, n), 32'({a_s, b_s}), 32'(k[1:0]));
                check($sformatf("d%0d_busy_n%0d", d, n), 32'(busy_s), 32'd1);
                check($sformatf("d%0d_done_lo_n%0d", d, n), 32'(done_s), 32'd0);
            end else if (n == win + 1) begin
                check($sformatf("d%0d_done_hi", d), 32'(done_s), 32'd1);
                check($sformatf("d%0d_busy_chk", d), 32'(busy_s), 32'd0);
                check($sformatf("d%0d_ab_chk", d), 32'({a_s, b_s}), 32'd0);
                check($sformatf("d%0d_tt", d), 32'(tt_s), 32'(tt_e));
                check($sformatf("d%0d_pass", d), 32'(pass_s), 32'(pass_e));
                check($sformatf("d%0d_err", d), 32'(err_s), 32'(err_e));
            end else begin
                check($sformatf("d%0d_done_after", d), 32'(done_s), 32'd0);
                check($sformatf("d%0d_tt_hold", d), 32'(tt_s), 32'(tt_e));
                check($sformatf("d%0d_pass_hold", d), 32'(pass_s), 32'(pass_e));
                check($sformatf("d%0d_err_hold", d), 32'(err_s), 32'(err_e));
            end
        end
        if (d == 0) sel0 = sel; else sel1 = sel;
    endtask

    initial begin
        int done_cnt;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sel0 = 3'd0; sel1 = 3'd0; mode = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ab",   32'({a0, b0}), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_pass", 32'(pass0), 32'd0);
        check("rst_tt",   32'(tt0), 32'd0);
        check("rst_err",  32'(err0), 32'd0);

        // 1: AND gate, AND expected
        do_sweep(0, 2, 3'd0, 0, 4'b1000, 1'b1, 4'b0000);
        // 2: OR gate, AND expected
        do_sweep(0, 2, 3'd0, 1, 4'b1110, 1'b0, 4'b0110);

        // 3: start held 20 cycles; accepted at T and T+14
        mode = 0;
        @(negedge clk);
        start0 = 1'b1; sel0 = 3'd0;
        done_cnt = 0;
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            if (done0) done_cnt++;
            check($sformatf("hold_done_n%0d", n), 32'(done0), 32'((n == 13) || (n == 27)));
            check($sformatf("hold_busy_n%0d", n), 32'(busy0),
                  32'(!((n == 13) || (n == 14) || (n >= 27))));
            if (n == 20) start0 = 1'b0;
        end
        check("hold_done_count", 32'(done_cnt), 32'd2);
        check("hold_tt", 32'(tt0), 32'b1000);
        check("hold_pass", 32'(pass0), 32'd1);

        // 4: reset while vector 2 is applied
        mode = 1;
        @(negedge clk);
        start0 = 1'b1; sel0 = 3'd0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) start0 = 1'b0;
        end
        check("pre_rst_tt", 32'(tt0), 32'b0010);
        check("pre_rst_ab", 32'({a0, b0}), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_ab",   32'({a0, b0}), 32'd0);
        check("mid_rst_tt",   32'(tt0), 32'd0);
        check("mid_rst_pass", 32'(pass0), 32'd0);
        check("mid_rst_done", 32'(done0), 32'd0);
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done0) done_cnt++;
        end
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        do_sweep(0, 2, 3'd0, 0, 4'b1000, 1'b1, 4'b0000);

        // 5: reserved gate_sel with AND gate
        do_sweep(0, 2, 3'd7, 0, 4'b1000, 1'b0, 4'b1111);

        // 6: SETTLE_CYCLES=1, Y tied 0, NOR expected
        do_sweep(1, 1, 3'd3, 2, 4'b0000, 1'b0, 4'b0001);

        // Extra: XOR gate sel with OR model on short-settle instance
        do_sweep(1, 1, 3'd4, 1, 4'b1110, 1'b0, 4'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
